ex_mem_stage: RTL and testbench

Execute stage plus EX/MEM pipeline register of the 5-stage pipeline. It sits directly downstream of the ID/EX register and consumes its outputs. It applies EX/MEM and MEM/WB forwarding, decodes ALU control, computes the ALU result, and runs a 32-cycle iterative multiplier that stalls the upstream pipe. It registers everything the MEM stage needs.

---
 rtl/pipe_pkg.sv | 57 +++++
 rtl/ex_mem_stage_if.sv | 27 ++
 rtl/seq_multiplier.sv | 90 +++++++++
 rtl/ex_mem_stage.sv | 136 +++++++++++++
 tb/tb_ex_mem_stage.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALUOp and funct encodings, ALU control
// and multiplier state enums, and the ALU control decode function.
package pipe_pkg;

    localparam int MUL_CYCLES_DEF = 32;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MUL
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_e;

    // Unknown ALUOp or funct falls back to add.
    function automatic alu_ctrl_e alu_decode(
        input logic [1:0] op,
        input logic [5:0] funct
    );
        alu_ctrl_e c;
        c = ALU_ADD;
        case (op)
            ALUOP_SUB: c = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_SUB: c = ALU_SUB;
                    FUNCT_AND: c = ALU_AND;
                    FUNCT_OR:  c = ALU_OR;
                    FUNCT_SLT: c = ALU_SLT;
                    FUNCT_MUL: c = ALU_MUL;
                    default:   c = ALU_ADD;
                endcase
            end
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM register outputs as seen by the MEM stage.
// master: driven by ex_mem_stage; slave: consumed by MEM.
interface ex_mem_stage_if;
    logic        RegWrite_out;
    logic        MemtoReg_out;
    logic        Branch_out;
    logic        MemRead_out;
    logic        MemWrite_out;
    logic [31:0] alu_result_out;
    logic        zero_out;
    logic [31:0] write_data_out;
    logic [4:0]  RegisterRd_out;

    modport master (
        output RegWrite_out, MemtoReg_out, Branch_out,
        output MemRead_out, MemWrite_out,
        output alu_result_out, zero_out,
        output write_data_out, RegisterRd_out
    );

    modport slave (
        input RegWrite_out, MemtoReg_out, Branch_out,
        input MemRead_out, MemWrite_out,
        input alu_result_out, zero_out,
        input write_data_out, RegisterRd_out
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per BUSY cycle.
// Ports: clk, reset (async low), start, abort, a, b -> busy, done, product.
module seq_multiplier
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    mul_state_e    state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [31:0]   mcand, mcand_nx;
    logic [31:0]   mplier, mplier_nx;
    logic [31:0]   acc, acc_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= MUL_IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            acc    <= acc_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        mcand_nx  = mcand;
        mplier_nx = mplier;
        acc_nx    = acc;
        unique case (state)
            MUL_IDLE: begin
                if (start && !abort) begin
                    state_nx  = MUL_BUSY;
                    count_nx  = '0;
                    mcand_nx  = a;
                    mplier_nx = b;
                    acc_nx    = '0;
                end
            end
            MUL_BUSY: begin
                if (abort) begin
                    state_nx = MUL_IDLE;
                    count_nx = '0;
                end else begin
                    if (mplier[0]) begin
                        acc_nx = acc + mcand;
                    end
                    mcand_nx  = mcand << 1;
                    mplier_nx = mplier >> 1;
                    count_nx  = count + 1'b1;
                    if (count == LAST) begin
                        state_nx = MUL_DONE;
                        count_nx = '0;
                    end
                end
            end
            MUL_DONE: begin
                state_nx = MUL_IDLE;
            end
            default: begin
                state_nx = MUL_IDLE;
            end
        endcase
    end

    assign busy    = (state == MUL_BUSY);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with forwarding, ALU, iterative mul and the EX/MEM register.
// Ports: ID/EX fields in, MEM/WB forward source, EX_Flush -> EX_stall, mem (EX/MEM).
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        Branch_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        ALUSrc_in,
    input  logic [1:0]  ALUOp_in,
    input  logic [31:0] reg_read_data_1_in,
    input  logic [31:0] reg_read_data_2_in,
    input  logic [31:0] immi_sign_extended_in,
    input  logic [4:0]  IF_ID_RegisterRs_in,
    input  logic [4:0]  IF_ID_RegisterRt_in,
    input  logic [4:0]  IF_ID_RegisterRd_in,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_RegisterRd,
    input  logic [31:0] MEM_WB_write_data,
    input  logic        EX_Flush,
    output logic        EX_stall,
    ex_mem_stage_if.master mem
);

    logic [31:0] fwd_a, fwd_b, op_b;
    logic [31:0] alu_result, mul_product;
    logic [4:0]  dest;
    alu_ctrl_e   alu_ctrl;
    logic        mul_start, mul_busy, mul_done;
    logic        bubble;
    logic        exm_hit_a, exm_hit_b, wb_hit_a, wb_hit_b;

    assign exm_hit_a = mem.RegWrite_out && (mem.RegisterRd_out != 5'd0)
                    && (mem.RegisterRd_out == IF_ID_RegisterRs_in);
    assign exm_hit_b = mem.RegWrite_out && (mem.RegisterRd_out != 5'd0)
                    && (mem.RegisterRd_out == IF_ID_RegisterRt_in);
    assign wb_hit_a  = MEM_WB_RegWrite && (MEM_WB_RegisterRd != 5'd0)
                    && (MEM_WB_RegisterRd == IF_ID_RegisterRs_in);
    assign wb_hit_b  = MEM_WB_RegWrite && (MEM_WB_RegisterRd != 5'd0)
                    && (MEM_WB_RegisterRd == IF_ID_RegisterRt_in);

    // The newer EX/MEM value shadows the older MEM/WB value.
    always_comb begin
        fwd_a = reg_read_data_1_in;
        if (exm_hit_a) begin
            fwd_a = mem.alu_result_out;
        end else if (wb_hit_a) begin
            fwd_a = MEM_WB_write_data;
        end
    end

    always_comb begin
        fwd_b = reg_read_data_2_in;
        if (exm_hit_b) begin
            fwd_b = mem.alu_result_out;
        end else if (wb_hit_b) begin
            fwd_b = MEM_WB_write_data;
        end
    end

    assign op_b     = ALUSrc_in ? immi_sign_extended_in : fwd_b;
    assign dest     = ALUSrc_in ? IF_ID_RegisterRt_in : IF_ID_RegisterRd_in;
    assign alu_ctrl = alu_decode(ALUOp_in, immi_sign_extended_in[5:0]);

    assign mul_start = (alu_ctrl == ALU_MUL) && !EX_Flush;

    seq_multiplier #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (EX_Flush),
        .a       (fwd_a),
        .b       (fwd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Issue cycle stalls combinationally; DONE releases the pipe.
    // Gated by reset so an asserted reset never reports a stall.
    assign EX_stall = reset
                   && ((mul_start && !mul_busy && !mul_done) || mul_busy);

    assign bubble = EX_Flush || EX_stall || mul_busy;

    always_comb begin
        alu_result = fwd_a + op_b;
        unique case (alu_ctrl)
            ALU_SUB: alu_result = fwd_a - op_b;
            ALU_AND: alu_result = fwd_a & op_b;
            ALU_OR:  alu_result = fwd_a | op_b;
            ALU_SLT: alu_result = {31'd0, $signed(fwd_a) < $signed(op_b)};
            ALU_MUL: alu_result = mul_product;
            default: alu_result = fwd_a + op_b;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem.RegWrite_out   <= 1'b0;
            mem.MemtoReg_out   <= 1'b0;
            mem.Branch_out     <= 1'b0;
            mem.MemRead_out    <= 1'b0;
            mem.MemWrite_out   <= 1'b0;
            mem.alu_result_out <= '0;
            mem.zero_out       <= 1'b0;
            mem.write_data_out <= '0;
            mem.RegisterRd_out <= '0;
        end else if (bubble) begin
            mem.RegWrite_out   <= 1'b0;
            mem.MemtoReg_out   <= 1'b0;
            mem.Branch_out     <= 1'b0;
            mem.MemRead_out    <= 1'b0;
            mem.MemWrite_out   <= 1'b0;
        end else begin
            mem.RegWrite_out   <= RegWrite_in;
            mem.MemtoReg_out   <= MemtoReg_in;
            mem.Branch_out     <= Branch_in;
            mem.MemRead_out    <= MemRead_in;
            mem.MemWrite_out   <= MemWrite_in;
            mem.alu_result_out <= alu_result;
            mem.zero_out       <= (alu_result == 32'h0);
            mem.write_data_out <= fwd_b;
            mem.RegisterRd_out <= dest;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: forwarding, ALU ops, mul, flush, reset.
// Expected values are hand-computed constants.
module tb_ex_mem_stage;
    import pipe_pkg::*;

    logic        clk;
    logic        reset;
    logic        RegWrite_in, MemtoReg_in, Branch_in;
    logic        MemRead_in, MemWrite_in, ALUSrc_in;
    logic [1:0]  ALUOp_in;
    logic [31:0] reg_read_data_1_in, reg_read_data_2_in;
    logic [31:0] immi_sign_extended_in;
    logic [4:0]  IF_ID_RegisterRs_in, IF_ID_RegisterRt_in;
    logic [4:0]  IF_ID_RegisterRd_in;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_RegisterRd;
    logic [31:0] MEM_WB_write_data;
    logic        EX_Flush;
    logic        EX_stall;

    int errors;
    int checks;

    ex_mem_stage_if mem_if ();

    ex_mem_stage #(.MUL_CYCLES(32)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .RegWrite_in           (RegWrite_in),
        .MemtoReg_in           (MemtoReg_in),
        .Branch_in             (Branch_in),
        .MemRead_in            (MemRead_in),
        .MemWrite_in           (MemWrite_in),
        .ALUSrc_in             (ALUSrc_in),
        .ALUOp_in              (ALUOp_in),
        .reg_read_data_1_in    (reg_read_data_1_in),
        .reg_read_data_2_in    (reg_read_data_2_in),
        .immi_sign_extended_in (immi_sign_extended_in),
        .IF_ID_RegisterRs_in   (IF_ID_RegisterRs_in),
        .IF_ID_RegisterRt_in   (IF_ID_RegisterRt_in),
        .IF_ID_RegisterRd_in   (IF_ID_RegisterRd_in),
        .MEM_WB_RegWrite       (MEM_WB_RegWrite),
        .MEM_WB_RegisterRd     (MEM_WB_RegisterRd),
        .MEM_WB_write_data     (MEM_WB_write_data),
        .EX_Flush              (EX_Flush),
        .EX_stall              (EX_stall),
        .mem                   (mem_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_instr(
        input logic rw, input logic m2r, input logic br,
        input logic mr, input logic mw, input logic src,
        input logic [1:0] op,
        input logic [31:0] d1, input logic [31:0] d2,
        input logic [31:0] imm,
        input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd
    );
        RegWrite_in = rw;
        MemtoReg_in = m2r;
        Branch_in = br;
        MemRead_in = mr;
        MemWrite_in = mw;
        ALUSrc_in = src;
        ALUOp_in = op;
        reg_read_data_1_in = d1;
        reg_read_data_2_in = d2;
        immi_sign_extended_in = imm;
        IF_ID_RegisterRs_in = rs;
        IF_ID_RegisterRt_in = rt;
        IF_ID_RegisterRd_in = rd;
    endtask

    task automatic set_rtype(
        input logic [5:0] funct,
        input logic [31:0] d1, input logic [31:0] d2,
        input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd
    );
        set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_RTYPE,
                  d1, d2, {26'd0, funct}, rs, rt, rd);
    endtask

    task automatic set_nop();
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD,
                  32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic set_fwd(
        input logic wr, input logic [4:0] rd,
        input logic [31:0] data
    );
        MEM_WB_RegWrite = wr;
        MEM_WB_RegisterRd = rd;
        MEM_WB_write_data = data;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        EX_Flush = 1'b0;
        set_nop();
        set_fwd(1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if (mem_if.RegWrite_out !== 1'b0 || mem_if.MemtoReg_out !== 1'b0
            || mem_if.Branch_out !== 1'b0 || mem_if.MemRead_out !== 1'b0
            || mem_if.MemWrite_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b%b%b%b%b want 00000",
                     mem_if.RegWrite_out, mem_if.MemtoReg_out,
                     mem_if.Branch_out, mem_if.MemRead_out,
                     mem_if.MemWrite_out);
        end
        checks++;
        if (mem_if.alu_result_out !== 32'h0 || mem_if.zero_out !== 1'b0
            || mem_if.write_data_out !== 32'h0
            || mem_if.RegisterRd_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: got alu=%h z=%b wd=%h rd=%0d want 0",
                     mem_if.alu_result_out, mem_if.zero_out,
                     mem_if.write_data_out, mem_if.RegisterRd_out);
        end
        checks++;
        if (EX_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", EX_stall);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        set_rtype(FUNCT_ADD, 32'd2, 32'd3, 5'd1, 5'd2, 5'd3);
        set_fwd(1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'd5 || mem_if.RegisterRd_out !== 5'd3
            || mem_if.RegWrite_out !== 1'b1) begin
            errors++;
            $display("FAIL fwd_base: got alu=%0d rd=%0d rw=%b want 5 3 1",
                     mem_if.alu_result_out, mem_if.RegisterRd_out,
                     mem_if.RegWrite_out);
        end
        // rs=3: EX/MEM has 5, MEM/WB has 7, reg file stale 9
        @(negedge clk);
        set_rtype(FUNCT_ADD, 32'd9, 32'd10, 5'd3, 5'd5, 5'd4);
        set_fwd(1'b1, 5'd3, 32'd7);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'd15) begin
            errors++;
            $display("FAIL fwd_exmem_prio_a: got %0d want 15",
                     mem_if.alu_result_out);
        end
        // rt=4: EX/MEM has 15, MEM/WB has 7, stale 1
        @(negedge clk);
        set_rtype(FUNCT_ADD, 32'd100, 32'd1, 5'd7, 5'd4, 5'd6);
        set_fwd(1'b1, 5'd4, 32'd7);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'd115
            || mem_if.write_data_out !== 32'd15) begin
            errors++;
            $display("FAIL fwd_exmem_b: got alu=%0d wd=%0d want 115 15",
                     mem_if.alu_result_out, mem_if.write_data_out);
        end
        // rt=10 only in MEM/WB
        @(negedge clk);
        set_rtype(FUNCT_ADD, 32'd1, 32'd2, 5'd9, 5'd10, 5'd8);
        set_fwd(1'b1, 5'd10, 32'd40);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'd41
            || mem_if.write_data_out !== 32'd40) begin
            errors++;
            $display("FAIL fwd_memwb_b: got alu=%0d wd=%0d want 41 40",
                     mem_if.alu_result_out, mem_if.write_data_out);
        end
        // write to r0, then read r0: never forwarded
        @(negedge clk);
        set_rtype(FUNCT_ADD, 32'd1, 32'd1, 5'd11, 5'd12, 5'd0);
        set_fwd(1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        set_rtype(FUNCT_ADD, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9);
        set_fwd(1'b1, 5'd0, 32'd77);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'd0 || mem_if.zero_out !== 1'b1) begin
            errors++;
            $display("FAIL fwd_r0: got alu=%0d z=%b want 0 1",
                     mem_if.alu_result_out, mem_if.zero_out);
        end
        set_fwd(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_alu();
        @(negedge clk);
        set_rtype(FUNCT_SLT, 32'hFFFF_FFFD, 32'd2, 5'd20, 5'd21, 5'd1);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'd1 || mem_if.zero_out !== 1'b0) begin
            errors++;
            $display("FAIL slt_neg: got alu=%0d z=%b want 1 0",
                     mem_if.alu_result_out, mem_if.zero_out);
        end
        @(negedge clk);
        set_rtype(FUNCT_SLT, 32'd2, 32'hFFFF_FFFD, 5'd20, 5'd21, 5'd1);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'd0 || mem_if.zero_out !== 1'b1) begin
            errors++;
            $display("FAIL slt_pos: got alu=%0d z=%b want 0 1",
                     mem_if.alu_result_out, mem_if.zero_out);
        end
        @(negedge clk);
        set_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_SUB,
                  32'd4, 32'd4, 32'h0, 5'd20, 5'd21, 5'd13);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'd0 || mem_if.zero_out !== 1'b1
            || mem_if.Branch_out !== 1'b1 || mem_if.RegWrite_out !== 1'b0
            || mem_if.RegisterRd_out !== 5'd13) begin
            errors++;
            $display("FAIL sub_zero: got alu=%0d z=%b br=%b rw=%b rd=%0d",
                     mem_if.alu_result_out, mem_if.zero_out,
                     mem_if.Branch_out, mem_if.RegWrite_out,
                     mem_if.RegisterRd_out);
        end
        @(negedge clk);
        set_rtype(FUNCT_AND, 32'h0000_F0F0, 32'h0000_FF00,
                  5'd20, 5'd21, 5'd1);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'h0000_F000) begin
            errors++;
            $display("FAIL and: got %h want 0000f000", mem_if.alu_result_out);
        end
        @(negedge clk);
        set_rtype(FUNCT_OR, 32'h0000_F0F0, 32'h0000_FF00,
                  5'd20, 5'd21, 5'd1);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'h0000_FFF0) begin
            errors++;
            $display("FAIL or: got %h want 0000fff0", mem_if.alu_result_out);
        end
        @(negedge clk);
        set_rtype(FUNCT_SUB, 32'd3, 32'd5, 5'd20, 5'd21, 5'd1);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL sub_wrap: got %h want fffffffe",
                     mem_if.alu_result_out);
        end
        @(negedge clk);
        set_rtype(6'b000111, 32'd3, 32'd4, 5'd20, 5'd21, 5'd1);
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'd7) begin
            errors++;
            $display("FAIL funct_default: got %0d want 7",
                     mem_if.alu_result_out);
        end
    endtask

    task automatic test_mul();
        int stall_cnt;
        int bubble_bad;
        stall_cnt = 0;
        bubble_bad = 0;
        @(negedge clk);
        set_rtype(FUNCT_MUL, 32'hFFFF_FFFF, 32'd3, 5'd20, 5'd21, 5'd2);
        set_fwd(1'b0, 5'd0, 32'd0);
        #1;
        for (int i = 0; i < 40; i++) begin
            if (EX_stall !== 1'b1) break;
            stall_cnt++;
            @(posedge clk); #1;
            if (mem_if.RegWrite_out !== 1'b0) bubble_bad++;
            if (i == 5) set_fwd(1'b1, 5'd20, 32'd0);
        end
        checks++;
        if (stall_cnt != 33) begin
            errors++;
            $display("FAIL mul_stall_len: got %0d want 33", stall_cnt);
        end
        checks++;
        if (bubble_bad != 0) begin
            errors++;
            $display("FAIL mul_bubbles: got %0d live cycles want 0",
                     bubble_bad);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'hFFFF_FFFD
            || mem_if.RegWrite_out !== 1'b1
            || mem_if.RegisterRd_out !== 5'd2
            || mem_if.write_data_out !== 32'd3) begin
            errors++;
            $display("FAIL mul_result: got alu=%h rw=%b rd=%0d wd=%h",
                     mem_if.alu_result_out, mem_if.RegWrite_out,
                     mem_if.RegisterRd_out, mem_if.write_data_out);
        end
        @(negedge clk);
        set_nop();
        set_fwd(1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if (EX_stall !== 1'b0) begin
            errors++;
            $display("FAIL mul_release: got stall=%b want 0", EX_stall);
        end
    endtask

    task automatic test_flush();
        int bad;
        bad = 0;
        // flush beats mul issue in IDLE
        @(negedge clk);
        set_rtype(FUNCT_MUL, 32'd7, 32'd6, 5'd20, 5'd21, 5'd3);
        EX_Flush = 1'b1;
        #1;
        checks++;
        if (EX_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue_stall: got %b want 0", EX_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_if.RegWrite_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue_bubble: got rw=%b want 0",
                     mem_if.RegWrite_out);
        end
        // abort at BUSY count 10
        @(negedge clk);
        EX_Flush = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        EX_Flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_if.RegWrite_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_bubble: got rw=%b want 0",
                     mem_if.RegWrite_out);
        end
        @(negedge clk);
        EX_Flush = 1'b0;
        set_rtype(FUNCT_ADD, 32'd5, 32'd6, 5'd20, 5'd21, 5'd3);
        #1;
        checks++;
        if (EX_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_abort_stall: got %b want 0", EX_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'd11 || mem_if.RegWrite_out !== 1'b1) begin
            errors++;
            $display("FAIL flush_next: got alu=%0d rw=%b want 11 1",
                     mem_if.alu_result_out, mem_if.RegWrite_out);
        end
        @(negedge clk);
        set_nop();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (mem_if.alu_result_out === 32'd42 || EX_stall !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_no_product: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        set_rtype(FUNCT_ADD, 32'd1, 32'd2, 5'd20, 5'd21, 5'd7);
        @(posedge clk); #1;
        @(negedge clk);
        set_rtype(FUNCT_MUL, 32'd5, 32'd9, 5'd20, 5'd21, 5'd2);
        repeat (21) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (mem_if.RegWrite_out !== 1'b0 || mem_if.alu_result_out !== 32'h0
            || mem_if.write_data_out !== 32'h0
            || mem_if.RegisterRd_out !== 5'd0 || EX_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got rw=%b alu=%h wd=%h rd=%0d st=%b",
                     mem_if.RegWrite_out, mem_if.alu_result_out,
                     mem_if.write_data_out, mem_if.RegisterRd_out, EX_stall);
        end
        set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ALUOP_ADD,
                  32'h100, 32'h0, 32'h8, 5'd22, 5'd5, 5'd9);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_if.alu_result_out !== 32'h108 || mem_if.RegisterRd_out !== 5'd5
            || mem_if.MemRead_out !== 1'b1 || mem_if.RegWrite_out !== 1'b1) begin
            errors++;
            $display("FAIL lw_after_reset: got alu=%h rd=%0d mr=%b rw=%b",
                     mem_if.alu_result_out, mem_if.RegisterRd_out,
                     mem_if.MemRead_out, mem_if.RegWrite_out);
        end
        checks++;
        if (EX_stall !== 1'b0) begin
            errors++;
            $display("FAIL lw_stall: got %b want 0", EX_stall);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_forwarding();
        test_alu();
        test_mul();
        test_flush();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
